// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate format encodings, imm_type_t and XLEN legality check shared by imm_gen_stage
package imm_gen_pkg;
  typedef logic [2:0] imm_type_t;
  localparam imm_type_t IMM_I = 3'b000;
  localparam imm_type_t IMM_S = 3'b001;
  localparam imm_type_t IMM_B = 3'b010;
  localparam imm_type_t IMM_U = 3'b011;
  localparam imm_type_t IMM_J = 3'b100;
  localparam imm_type_t IMM_Z = 3'b101;
  function automatic bit xlen_legal(input int xlen);
    return xlen == 32 || xlen == 64;
  endfunction
endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational I/S/B/U/J immediate decode (Z type when IMM_GEN_ZICSR_EN), ports instr/imm_type in, imm/err out
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            err
);
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (imm_type)
      IMM_I: imm = XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
`ifdef IMM_GEN_ZICSR_EN
      IMM_Z: imm = XLEN'(instr[19:15]);
`else
      IMM_Z: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate decode with 2-entry skid buffer (valid/ready in, valid/ready out; Z type via IMM_GEN_ZICSR_EN)
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_imm_err
);
  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             acc, drain, load_main, load_skid, skid_to_main;
  logic             main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
  logic [XLEN-1:0]  main_imm_d, main_imm_q, skid_imm_d, skid_imm_q;
  logic [TAG_W-1:0] main_tag_d, main_tag_q, skid_tag_d, skid_tag_q;
  logic             main_err_d, main_err_q, skid_err_d, skid_err_q;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm_type(in_imm_type),
    .imm     (dec_imm),
    .err     (dec_err)
  );
  assign in_ready    = !skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_imm_err = main_err_q;
  always_comb begin
    acc          = in_valid && in_ready;
    drain        = main_valid_q && out_ready;
    load_main    = acc && (!main_valid_q || drain);
    load_skid    = acc && !load_main;
    skid_to_main = drain && skid_valid_q;
    main_valid_d = !flush && (load_main || skid_valid_q || (main_valid_q && !drain));
    skid_valid_d = !flush && (skid_valid_q ? !drain : load_skid);
    main_imm_d   = load_main ? dec_imm : skid_to_main ? skid_imm_q : main_imm_q;
    main_tag_d   = load_main ? in_tag  : skid_to_main ? skid_tag_q : main_tag_q;
    main_err_d   = load_main ? dec_err : skid_to_main ? skid_err_q : main_err_q;
    skid_imm_d   = load_skid ? dec_imm : skid_imm_q;
    skid_tag_d   = load_skid ? in_tag  : skid_tag_q;
    skid_err_d   = load_skid ? dec_err : skid_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed and random checks of imm_gen_stage (XLEN 64 and 32 side by side) against a FIFO reference model
module tb_imm_gen_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_imm_type = '0;
  logic [63:0] in_tag = '0;
  logic        a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [63:0] a_imm, a_tag;
  logic [31:0] b_imm, b_tag;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {logic [63:0] imm; logic [63:0] tag; logic err;} ent_t;
  ent_t        q[$];
  logic [31:0] tp_instr[5] = '{32'hFFF00093, 32'hFE113C23, 32'hFE000EE3, 32'h123450B7, 32'h0080006F};
  logic [63:0] tp_imm[5]   = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                               64'h0000000012345000, 64'h0000000000000008};
  logic [63:0] tp_exp;
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(64), .TAG_W(64)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag), .out_valid(a_valid),
    .out_ready(out_ready), .out_imm(a_imm), .out_tag(a_tag), .out_imm_err(a_err)
  );
  imm_gen_stage #(.XLEN(32), .TAG_W(32)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag[31:0]), .out_valid(b_valid),
    .out_ready(out_ready), .out_imm(b_imm), .out_tag(b_tag), .out_imm_err(b_err)
  );
  function automatic longint sx(input longint x, input int n);
    return x >= (64'sd1 <<< (n - 1)) ? x - (64'sd1 <<< n) : x;
  endfunction
  function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] t);
    longint u, v;
    u = longint'({32'd0, ins});
    case (t)
      3'd0: v = sx(u >> 20, 12);
      3'd1: v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd2: v = sx(((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      3'd3: v = sx(u & 64'hFFFFF000, 32);
      3'd4: v = sx(((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
`ifdef IMM_GEN_ZICSR_EN
      3'd5: v = (u >> 15) & 31;
`endif
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, 64'(v)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rnd_in();
    in_instr    = $urandom;
    in_imm_type = 3'($urandom_range(0, 7));
    in_tag      = {$urandom, $urandom};
  endtask
  task automatic tick();
    bit          rdy, drn;
    ent_t        e;
    logic [64:0] r;
    @(negedge clk);
    chk("a_valid", 64'(a_valid), 64'(q.size() > 0));
    chk("b_valid", 64'(b_valid), 64'(q.size() > 0));
    chk("a_ready", 64'(a_ready), 64'(q.size() < 2));
    chk("b_ready", 64'(b_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("a_imm", a_imm, q[0].imm);
      chk("a_tag", a_tag, q[0].tag);
      chk("a_err", 64'(a_err), 64'(q[0].err));
      chk("b_imm", 64'(b_imm), 64'(q[0].imm[31:0]));
      chk("b_tag", 64'(b_tag), 64'(q[0].tag[31:0]));
      chk("b_err", 64'(b_err), 64'(q[0].err));
    end
    rdy = q.size() < 2;
    drn = q.size() > 0 && out_ready;
    if (rst || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (in_valid && rdy) begin
        r = ref_imm(in_instr, in_imm_type);
        e.imm = r[63:0];
        e.err = r[64];
        e.tag = in_tag;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_imm", a_imm, 64'd0);
    chk("rst_tag", a_tag, 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd1);
    chk("rst_b_imm", 64'(b_imm), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid    = 1'b1;
      in_instr    = tp_instr[k];
      in_imm_type = 3'(k);
      in_tag      = {$urandom, $urandom};
      tick();
      tp_exp = tp_imm[k];
      chk("tp_valid", 64'(a_valid), 64'd1);
      chk("tp_imm64", a_imm, tp_exp);
      chk("tp_imm32", 64'(b_imm), 64'(tp_exp[31:0]));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rnd_in();
    tick();
    rnd_in();
    tick();
    chk("bp_ready_low", 64'(a_ready), 64'd0);
    rnd_in();
    tick();
    chk("bp_ready_held", 64'(a_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 64'(a_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rnd_in();
    tick();
    rnd_in();
    tick();
    chk("fl_full", 64'(a_ready), 64'd0);
    flush = 1'b1;
    rnd_in();
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(a_valid), 64'd0);
    chk("fl_ready", 64'(a_ready), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    in_valid    = 1'b1;
    in_instr    = 32'h0002D073;
    in_imm_type = 3'b101;
    tick();
`ifdef IMM_GEN_ZICSR_EN
    chk("z_imm", a_imm, 64'd5);
    chk("z_err", 64'(a_err), 64'd0);
`else
    chk("z_imm", a_imm, 64'd0);
    chk("z_err", 64'(a_err), 64'd1);
`endif
    in_imm_type = 3'b111;
    tick();
    chk("rsv_imm", a_imm, 64'd0);
    chk("rsv_err", 64'(a_err), 64'd1);
    chk("rsv_b_err", 64'(b_err), 64'd1);
    in_valid = 1'b0;
    tick();
    repeat (400) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 31) == 0;
      rnd_in();
      tick();
    end
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rnd_in();
    tick();
    rnd_in();
    tick();
    rst = 1'b1;
    rnd_in();
    tick();
    chk("mrst_valid", 64'(a_valid), 64'd0);
    chk("mrst_imm", a_imm, 64'd0);
    chk("mrst_b_valid", 64'(b_valid), 64'd0);
    chk("mrst_b_imm", 64'(b_imm), 64'd0);
    chk("mrst_ready", 64'(a_ready), 64'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
